clk_div_prog: RTL and testbench

CLK_DIV_PROG -- requirements
Module: clk_div_prog

---
 rtl/clk_div_prog.sv | 93 +++++++++
 tb/tb_clk_div_prog.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider: per-channel ratio, run enable,
// deferred ratio reload at period wrap, and a global phase-align strobe.
module clk_div_prog #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned CW      = 8,
  parameter int unsigned DEF_DIV = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    en,
  input  logic [NCH-1:0]    load,
  input  logic [NCH*CW-1:0] div_ratio,
  input  logic              sync_start,
  output logic [NCH-1:0]    clk_out,
  output logic [NCH-1:0]    tick,
  output logic [NCH-1:0]    cfg_err
);

  localparam logic [CW-1:0] DEF_RATIO = CW'(DEF_DIV);
  localparam logic [CW-1:0] MIN_RATIO = CW'(2);

  logic [CW-1:0] n_q     [NCH];
  logic [CW-1:0] p_q     [NCH];
  logic [CW-1:0] cnt_q   [NCH];
  logic [NCH-1:0] active_q;

  logic [CW-1:0] req     [NCH];
  logic [CW-1:0] ld_val  [NCH];
  logic [CW-1:0] cnt_inc [NCH];
  logic [CW:0]   high    [NCH];
  logic [NCH-1:0] bad;
  logic [NCH-1:0] wrap;

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      req[i]     = div_ratio[i*CW +: CW];
      bad[i]     = req[i] < MIN_RATIO;
      ld_val[i]  = bad[i] ? MIN_RATIO : req[i];
      cnt_inc[i] = cnt_q[i] + CW'(1);
      // high time computed one bit wider so N = 2^CW-1 does not overflow
      high[i]    = ({1'b0, n_q[i]} + (CW+1)'(1)) >> 1;
      wrap[i]    = cnt_q[i] == (n_q[i] - CW'(1));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        n_q[i]   <= DEF_RATIO;
        p_q[i]   <= DEF_RATIO;
        cnt_q[i] <= '0;
      end
      active_q <= '0;
      clk_out  <= '0;
      tick     <= '0;
      cfg_err  <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        // an idle (or stopping) channel takes a new ratio immediately;
        // a running one only stages it for the next wrap
        if (load[i]) begin
          cfg_err[i] <= bad[i];
          p_q[i]     <= ld_val[i];
          if (!active_q[i] || !en[i])
            n_q[i] <= ld_val[i];
        end

        if (!en[i]) begin
          active_q[i] <= 1'b0;
          cnt_q[i]    <= '0;
          clk_out[i]  <= 1'b0;
          tick[i]     <= 1'b0;
        end else if (!active_q[i]) begin
          active_q[i] <= 1'b1;
          cnt_q[i]    <= '0;
          clk_out[i]  <= 1'b1;
          tick[i]     <= 1'b1;
        end else if (sync_start || wrap[i]) begin
          // reads the pre-edge pending ratio, so a load on this edge waits a period
          n_q[i]     <= p_q[i];
          cnt_q[i]   <= '0;
          clk_out[i] <= 1'b1;
          tick[i]    <= 1'b1;
        end else begin
          cnt_q[i]   <= cnt_inc[i];
          clk_out[i] <= {1'b0, cnt_inc[i]} < high[i];
          tick[i]    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: table vectors, directed corner
// sequences and randomized traffic against a period-position reference model.
module tb_clk_div_prog;

  logic        clk;
  logic        reset;
  logic [3:0]  en;
  logic [3:0]  load;
  logic [31:0] div_ratio;
  logic        sync_start;
  logic [3:0]  clk_out;
  logic [3:0]  tick;
  logic [3:0]  cfg_err;

  int n_cmp = 0;
  int n_bad = 0;

  clk_div_prog #(.NCH(4), .CW(8), .DEF_DIV(2)) dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .div_ratio(div_ratio),
    .sync_start(sync_start), .clk_out(clk_out), .tick(tick), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: each channel remembers its period length and how far into the
  // current period it is; outputs are derived from that position.
  int m_n[4], m_p[4], m_pos[4];
  bit m_act[4], m_err[4];

  function automatic void model_reset();
    for (int c = 0; c < 4; c++) begin
      m_n[c] = 2; m_p[c] = 2; m_pos[c] = 0; m_act[c] = 0; m_err[c] = 0;
    end
  endfunction

  function automatic void model_step();
    for (int c = 0; c < 4; c++) begin
      int v, val, staged;
      v = int'(div_ratio[c*8 +: 8]);
      staged = m_p[c];
      if (load[c]) begin
        m_err[c] = (v < 2);
        val = (v < 2) ? 2 : v;
        m_p[c] = val;
        if (!m_act[c] || !en[c]) m_n[c] = val;
      end
      if (!en[c]) begin
        m_act[c] = 0; m_pos[c] = 0;
      end else if (!m_act[c]) begin
        m_act[c] = 1; m_pos[c] = 0;
      end else if (sync_start || (m_pos[c] + 1 == m_n[c])) begin
        m_pos[c] = 0; m_n[c] = staged;
      end else begin
        m_pos[c] = m_pos[c] + 1;
      end
    end
  endfunction

  function automatic logic [3:0] exp_clk();
    logic [3:0] r = '0;
    for (int c = 0; c < 4; c++) r[c] = m_act[c] && (m_pos[c] < (m_n[c] + 1) / 2);
    return r;
  endfunction

  function automatic logic [3:0] exp_tick();
    logic [3:0] r = '0;
    for (int c = 0; c < 4; c++) r[c] = m_act[c] && (m_pos[c] == 0);
    return r;
  endfunction

  function automatic logic [3:0] exp_err();
    logic [3:0] r = '0;
    for (int c = 0; c < 4; c++) r[c] = m_err[c];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".clk_out"}, 32'(clk_out), 32'(exp_clk()));
    chk({tag, ".tick"},    32'(tick),    32'(exp_tick()));
    chk({tag, ".cfg_err"}, 32'(cfg_err), 32'(exp_err()));
  endtask

  task automatic step(input logic [3:0] e, input logic [3:0] l,
                      input logic [31:0] r, input logic s);
    en = e; load = l; div_ratio = r; sync_start = s;
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct {
    logic [3:0]  en;
    logic [3:0]  load;
    logic [31:0] ratio;
    logic [3:0]  ec;
    logic [3:0]  et;
    logic [3:0]  ee;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [0:10] ec032;
    logic [0:11] ec033;

    // ratios 2/3/4/5 loaded idle, then all channels run together
    tbl[0] = '{4'h0, 4'hF, 32'h05040302, 4'h0, 4'h0, 4'h0};
    tbl[1] = '{4'hF, 4'h0, 32'h0, 4'hF, 4'hF, 4'h0};
    tbl[2] = '{4'hF, 4'h0, 32'h0, 4'hE, 4'h0, 4'h0};
    tbl[3] = '{4'hF, 4'h0, 32'h0, 4'h9, 4'h1, 4'h0};
    tbl[4] = '{4'hF, 4'h0, 32'h0, 4'h2, 4'h2, 4'h0};
    tbl[5] = '{4'hF, 4'h0, 32'h0, 4'h7, 4'h5, 4'h0};
    tbl[6] = '{4'hF, 4'h0, 32'h0, 4'hC, 4'h8, 4'h0};
    tbl[7] = '{4'hF, 4'h0, 32'h0, 4'hB, 4'h3, 4'h0};
    tbl[8] = '{4'hF, 4'h0, 32'h0, 4'hA, 4'h0, 4'h0};
    ec032 = 11'b11001110001;
    ec033 = 12'b110011001101;

    en = '0; load = '0; div_ratio = '0; sync_start = 1'b0;
    reset = 1'b0;
    model_reset();
    #3;
    chk("reset.clk_out", 32'(clk_out), 32'h0);
    chk("reset.tick",    32'(tick),    32'h0);
    chk("reset.cfg_err", 32'(cfg_err), 32'h0);
    @(posedge clk); #3;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset.clk_out", 32'(clk_out), 32'h0);

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].en, tbl[i].load, tbl[i].ratio, 1'b0);
      chk($sformatf("tbl%0d.clk_out", i), 32'(clk_out), 32'(tbl[i].ec));
      chk($sformatf("tbl%0d.tick", i),    32'(tick),    32'(tbl[i].et));
      chk($sformatf("tbl%0d.cfg_err", i), 32'(cfg_err), 32'(tbl[i].ee));
    end

    // deferred load: N=4 running, 6 staged while cnt=1
    step(4'h0, 4'h0, 32'h0, 1'b0);
    step(4'h0, 4'h1, 32'h4, 1'b0);
    for (int k = 0; k < 11; k++) begin
      step(4'h1, (k == 2) ? 4'h1 : 4'h0, 32'h6, 1'b0);
      chk($sformatf("defer%0d.clk0", k), 32'(clk_out[0]), 32'(ec032[k]));
      chk($sformatf("defer%0d.tick0", k), 32'(tick[0]), 32'(k == 0 || k == 4 || k == 10));
      chk_model("defer");
    end

    // load landing on the wrap edge: one more old period first
    step(4'h0, 4'h0, 32'h0, 1'b0);
    step(4'h0, 4'h1, 32'h4, 1'b0);
    for (int k = 0; k < 12; k++) begin
      step(4'h1, (k == 4) ? 4'h1 : 4'h0, 32'h3, 1'b0);
      chk($sformatf("wrapload%0d.clk0", k), 32'(clk_out[0]), 32'(ec033[k]));
      chk_model("wrapload");
    end

    // illegal ratio clamps to 2 and flags; legal reload clears
    step(4'h0, 4'h0, 32'h0, 1'b0);
    step(4'h0, 4'h2, 32'h0, 1'b0);
    chk("illegal.cfg_err", 32'(cfg_err), 32'h2);
    for (int k = 0; k < 3; k++) begin
      step(4'h2, 4'h0, 32'h0, 1'b0);
      chk($sformatf("clamp%0d.clk1", k), 32'(clk_out[1]), 32'(k != 1));
    end
    step(4'h2, 4'h2, 32'h0700, 1'b0);
    chk("legal.cfg_err", 32'(cfg_err), 32'h0);

    // phase alignment of ch0 (N=4) and ch2 (N=6); ch3 held off
    step(4'h0, 4'h0, 32'h0, 1'b0);
    step(4'h0, 4'h5, 32'h00060004, 1'b0);
    step(4'h1, 4'h0, 32'h0, 1'b0);
    step(4'h5, 4'h0, 32'h0, 1'b0);
    step(4'h5, 4'h0, 32'h0, 1'b0);
    step(4'h5, 4'h0, 32'h0, 1'b1);
    chk("sync.clk_out", 32'(clk_out), 32'h5);
    chk("sync.tick",    32'(tick),    32'h5);
    step(4'h5, 4'h0, 32'h0, 1'b0);
    chk_model("post_sync");

    // stop mid-period, then asynchronous reset between edges
    step(4'h0, 4'h0, 32'h0, 1'b0);
    step(4'h0, 4'h9, 32'h01000004, 1'b0);
    for (int k = 0; k < 3; k++) step(4'hF, 4'h0, 32'h0, 1'b0);
    step(4'hE, 4'h0, 32'h0, 1'b0);
    chk("stop.clk0",  32'(clk_out[0]), 32'h0);
    chk("stop.tick0", 32'(tick[0]),    32'h0);
    chk_model("stop");
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("async_reset.clk_out", 32'(clk_out), 32'h0);
    chk("async_reset.tick",    32'(tick),    32'h0);
    chk("async_reset.cfg_err", 32'(cfg_err), 32'h0);
    #2;
    reset = 1'b1;
    step(4'hF, 4'h0, 32'h0, 1'b0);
    chk("def_div0.clk_out", 32'(clk_out), 32'hF);
    step(4'hF, 4'h0, 32'h0, 1'b0);
    chk("def_div1.clk_out", 32'(clk_out), 32'h0);
    step(4'hF, 4'h0, 32'h0, 1'b0);
    chk("def_div2.clk_out", 32'(clk_out), 32'hF);

    // randomized traffic against the reference model
    for (int k = 0; k < 400; k++) begin
      logic [3:0]  e, l;
      logic [31:0] r;
      logic        s;
      for (int c = 0; c < 4; c++) begin
        e[c] = ($urandom_range(0, 15) != 0);
        l[c] = ($urandom_range(0, 9) == 0);
        r[c*8 +: 8] = 8'($urandom_range(0, 9));
      end
      s = ($urandom_range(0, 19) == 0);
      step(e, l, r, s);
      chk_model("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
